// File: rtl/seqgen_pkg.sv
// seqgen_pkg: shared FSM encoding, default pattern and counter widths for seqgen_58
package seqgen_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_FIN  = 2'd3
  } state_t;
  localparam logic [7:0] DEF_PATTERN = 8'h58;
  localparam int BIT_W = 3;
  localparam int GAP_W = 4;
  localparam int REP_W = 4;
  // Bit of the 8-bit shift image that carries time index len-4 (MSB is time 0)
  function automatic logic [7:0] inj_mask(input int len);
    return (len >= 4) ? (8'h80 >> (len - 4)) : 8'h00;
  endfunction
endpackage

// File: rtl/seqgen_shreg.sv
// seqgen_shreg: parallel-load, shift-left 8-bit register whose MSB is the serial bit
module seqgen_shreg (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic       i_shift,
  input  logic [7:0] i_d,
  output logic       o_msb
);
  logic [7:0] r_q;
  // Load has priority over shift; zero is shifted in at the LSB
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_q <= '0;
    else r_q <= i_load ? i_d : i_shift ? {r_q[6:0], 1'b0} : r_q;
  assign o_msb = r_q[7];
endmodule

// File: rtl/seqgen_58.sv
// seqgen_58: serial pattern transmitter (optional SEQGEN_ERR_INJ_EN adds err_inj corruption of the final repetition)
module seqgen_58 import seqgen_pkg::*; #(
  parameter logic [7:0] PATTERN = DEF_PATTERN,
  parameter int LEN = 8,
  parameter int GAP = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [REP_W-1:0] reps,
`ifdef SEQGEN_ERR_INJ_EN
  input  logic             err_inj,
`endif
  output logic             out,
  output logic             valid,
  output logic             busy,
  output logic             done
);
  state_t r_state, w_nxt;
  logic [BIT_W-1:0] r_bit_cnt, w_bit_nxt;
  logic [GAP_W-1:0] r_gap_cnt, w_gap_nxt;
  logic [REP_W-1:0] r_rep_cnt, w_rep_nxt;
  logic w_load, w_shift, w_reload, w_err;
  logic [7:0] w_ld_val;
  logic r_valid, r_busy, r_done;
`ifdef SEQGEN_ERR_INJ_EN
  logic r_err;
  // Error-inject request is latched together with an accepted start
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_err <= 1'b0;
    else if (r_state == S_IDLE && start) r_err <= err_inj;
  assign w_err = (r_state == S_IDLE) ? err_inj : r_err;
`else
  assign w_err = 1'b0;
`endif
  // Next-state logic; the shift register holds the bit on out, so a reload puts bit 0 on out next cycle
  always_comb begin
    w_nxt = r_state;
    w_bit_nxt = r_bit_cnt;
    w_gap_nxt = r_gap_cnt;
    w_rep_nxt = r_rep_cnt;
    w_load = 1'b0;
    w_shift = 1'b0;
    w_reload = 1'b0;
    case (r_state)
      S_IDLE: if (start) begin
        w_nxt = S_SEND;
        w_reload = 1'b1;
        w_rep_nxt = (reps == '0) ? '0 : reps - 4'd1;
      end
      S_SEND: if (r_bit_cnt != '0) begin
        w_shift = 1'b1;
        w_bit_nxt = r_bit_cnt - 3'd1;
      end else if (r_rep_cnt != '0) begin
        w_rep_nxt = r_rep_cnt - 4'd1;
        if (GAP == 0) w_reload = 1'b1;
        else begin
          w_nxt = S_GAP;
          w_load = 1'b1;
          w_gap_nxt = GAP_W'(GAP - 1);
        end
      end else begin
        w_nxt = S_FIN;
        w_load = 1'b1;
      end
      S_GAP: if (r_gap_cnt == '0) begin
        w_nxt = S_SEND;
        w_reload = 1'b1;
      end else w_gap_nxt = r_gap_cnt - 4'd1;
      default: w_nxt = S_IDLE;
    endcase
    if (w_reload) begin
      w_load = 1'b1;
      w_bit_nxt = BIT_W'(LEN - 1);
    end
    w_ld_val = w_reload ? (PATTERN ^ ((w_err && w_rep_nxt == '0) ? inj_mask(LEN) : 8'h00)) : 8'h00;
  end
  // State, counters and registered status outputs derived from the next state
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= S_IDLE;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_rep_cnt <= '0;
      r_valid <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_gap_cnt <= w_gap_nxt;
      r_rep_cnt <= w_rep_nxt;
      r_valid <= (w_nxt == S_SEND);
      r_busy <= (w_nxt == S_SEND) || (w_nxt == S_GAP);
      r_done <= (w_nxt == S_FIN);
    end
  seqgen_shreg u_shreg (
    .clk(clk),
    .rst(rst),
    .i_load(w_load),
    .i_shift(w_shift),
    .i_d(w_ld_val),
    .o_msb(out)
  );
  assign valid = r_valid;
  assign busy = r_busy;
  assign done = r_done;
endmodule

// File: tb/tb_seqgen_58.sv
// tb_seqgen_58: randomized scoreboard bench for seqgen_58
module tb_seqgen_58;
  localparam logic [7:0] PAT = 8'h58;
  localparam int LEN = 8;
  localparam int GAP = 2;
  logic clk = 0, rst = 0, start = 0, err_inj = 0;
  logic [3:0] reps = 0;
  logic out, valid, busy, done;
  int errors = 0, checks = 0;
  bit exp_bits[$];
  int exp_busy[$];
  always #5 clk = ~clk;
  seqgen_58 #(.PATTERN(PAT), .LEN(LEN), .GAP(GAP)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .reps(reps),
`ifdef SEQGEN_ERR_INJ_EN
    .err_inj(err_inj),
`endif
    .out(out),
    .valid(valid),
    .busy(busy),
    .done(done)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Reference model: the job is the pattern's time-ordered bits repeated n times with GAP idle cycles between
  function automatic void push_job(input int r, input bit e);
    int n;
    logic [7:0] p;
    bit b;
    n = (r == 0) ? 1 : r;
    p = PAT;
    exp_busy.push_back(n * LEN + (n - 1) * GAP);
    for (int k = 0; k < n; k++)
      for (int t = 0; t < LEN; t++) begin
        b = p[7 - t];
        if (e && k == n - 1 && t == LEN - 4) b = ~b;
        exp_bits.push_back(b);
      end
  endfunction
  int bcnt = 0;
  logic pvalid = 0;
  // Monitor: pops expected bits on valid, checks busy length and done timing
  always @(negedge clk) begin
    if (!rst) begin
      bcnt = 0;
      pvalid = 0;
    end else begin
      if (valid) begin
        if (exp_bits.size() == 0) check("unexpected bit", 1, 0);
        else check("out bit", 32'(out), 32'(exp_bits.pop_front()));
      end else check("idle out zero", 32'(out), 0);
      if (busy) bcnt++;
      if (done) begin
        check("done after last bit", 32'(pvalid), 1);
        check("busy off at done", 32'(busy), 0);
        if (exp_busy.size() == 0) check("spurious done", 1, 0);
        else check("busy cycles", bcnt, exp_busy.pop_front());
        check("bits drained", exp_bits.size(), 0);
        bcnt = 0;
      end
      pvalid = valid;
    end
  end
  task automatic run_job(input int r, input bit junk, input bit fin_start);
    bit e;
    @(negedge clk);
    e = 1'($urandom % 2);
    start = 1;
    reps = r[3:0];
    err_inj = e;
`ifdef SEQGEN_ERR_INJ_EN
    push_job(r, e);
`else
    push_job(r, 0);
`endif
    @(negedge clk);
    start = 0;
    reps = 4'($urandom);
    err_inj = 1'($urandom);
    check("first bit latency", 32'({valid, busy}), 2'b11);
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      start = 0;
      if (!done && busy && junk && $urandom % 3 == 0) begin
        start = 1;
        reps = 4'($urandom);
      end
    end
    if (!done) check("done timeout", 0, 1);
    else if (fin_start) begin
      start = 1;
      reps = 4'($urandom);
      @(negedge clk);
      start = 0;
      check("start in FIN ignored", 32'(valid), 0);
      @(negedge clk);
      check("still idle", 32'({valid, busy}), 0);
    end
  endtask
  task automatic reset_mid();
    @(negedge clk);
    start = 1;
    reps = 1;
    err_inj = 0;
    push_job(1, 0);
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 0;
    #1 check("async reset outputs", 32'({out, valid, busy, done}), 0);
    exp_bits.delete();
    exp_busy.delete();
    repeat (2) @(negedge clk);
    rst = 1;
    run_job(1, 0, 0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("reset state", 32'({out, valid, busy, done}), 0);
    rst = 1;
    run_job(1, 0, 0);
    run_job(3, 0, 0);
    run_job(0, 0, 0);
    run_job(2, 1, 1);
    reset_mid();
    repeat (20) run_job(int'($urandom_range(0, 15)), 1'($urandom % 2), 1'($urandom % 2));
    repeat (5) @(negedge clk);
    check("queues drained", exp_busy.size() + exp_bits.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seqgen_58.md
Name: seqgen_58

Overview:
Serial pattern transmitter that drives the single-bit stream consumed by seqdec_58.
- On a start request, shifts out PATTERN (default 8'h58) MSB first, one bit per clk.
- Sends the pattern a programmable number of times, with a fixed gap of idle-0 bits between repetitions.
- Serves as the stimulus source paired with the detector in datapath and bench builds.

Parameters:
PATTERN, 8'h58, bit pattern transmitted MSB first (time order 0,1,0,1,1,0,0,0)
LEN, 8, pattern length in bits (1..8; only the upper LEN bits of PATTERN are sent)
GAP, 2, idle cycles (out=0) between repetitions (0..15)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low
start  in  1  request pulse; sampled only in IDLE
reps  in  4  repetitions to send; captured with start; 0 is treated as 1
out  out  1  serial data bit (feeds seqdec_58 in)
valid  out  1  high while out carries a pattern bit (not during gap or idle)
busy  out  1  high from the cycle after start is accepted until return to IDLE
done  out  1  one-cycle pulse on the final pattern bit's following cycle

Behaviour:
- Reset (rst=0, async): state=IDLE; out=0, valid=0, busy=0, done=0; bit counter, gap counter and rep counter are cleared.
- All outputs are registered and there is no combinational input-to-output path.
- FSM states: IDLE, SEND, GAP, FIN.
- IDLE:
  - On start=1: load the shift register with PATTERN, bit_cnt=LEN-1, rep_cnt=max(reps,1)-1, then go to SEND.
  - Latency: the first pattern bit appears on out, with valid=1 and busy=1, in the cycle after start is sampled.
- SEND:
  - Each cycle, out = current MSB of the shift register; shift left; decrement bit_cnt.
  - When bit_cnt==0 (last bit is on out this cycle):
    - if rep_cnt!=0, decrement rep_cnt and go to GAP (or straight back to SEND with a reloaded pattern if GAP==0);
    - otherwise go to FIN.
- GAP: out=0, valid=0, busy=1 for exactly GAP cycles; then reload PATTERN and bit_cnt, and go to SEND.
- FIN: done=1 for one cycle, out=0, valid=0, busy=0; next state is IDLE.
- start while busy (SEND/GAP/FIN): ignored, with no queuing.
- start in the cycle where FIN returns to IDLE is sampled only once the FSM is in IDLE, i.e. the following cycle.
- Back-to-back jobs: minimum spacing between the last bit of one job and the first bit of the next is 2 cycles (FIN, IDLE).
- Total busy cycles for reps=N: N*LEN + (N-1)*GAP.
- reps=0 behaves exactly as reps=1.
- Counter widths: bit_cnt 3 bits, gap_cnt 4 bits, rep_cnt 4 bits; no wrap-around is possible within legal parameter ranges.
- rst asserted mid-transmission: immediate return to IDLE with all outputs 0; the partial pattern is abandoned and done is not pulsed.

Optional Feature:
SEQGEN_ERR_INJ_EN
- Defined:
  - Adds input port err_inj (1 bit), sampled with start.
  - If set, the pattern bit at index LEN-4 of the final repetition only is inverted, so that seqdec_58 must NOT assert out for that repetition.
  - done still pulses normally.
- Undefined: the port is absent and every repetition is sent unmodified.

Decomposition:
- Package seqgen_pkg holds:
  - the state encoding constants (IDLE=2'd0, SEND=2'd1, GAP=2'd2, FIN=2'd3);
  - the default PATTERN (8'h58);
  - counter width constants.
- One sub-module, seqgen_shreg: parallel-load, shift-left 8-bit register with load/shift enables and MSB output, async active-low reset.
- The FSM and counters stay in seqgen_58.

Test Plan:
- Reset hold, then start=1, reps=1 → out over 8 cycles = 0,1,0,1,1,0,0,0 with valid=1 throughout; busy high 8 cycles; done pulses in cycle 9.
- start=1, reps=3, GAP=2 → 3 patterns separated by 2 cycles of out=0/valid=0; busy for 28 cycles; seqdec_58 out asserts 3 times.
- reps=0 → identical waveform to reps=1.
- start pulsed again during SEND and during FIN → no effect; the next job's first bit occurs only after IDLE is re-entered.
- rst driven low at bit 4 of the pattern → out/valid/busy drop to 0 asynchronously and done is not pulsed; a fresh start afterwards sends the full pattern.
- With SEQGEN_ERR_INJ_EN: reps=2, err_inj=1 → the first pattern is detected; the second is sent as 0,1,0,1,0,0,0,0 and is not detected; done still pulses.
